pb_prog_loader: RTL and testbench

Writer side of the PicoBlaze program memory: receives a framed byte stream (from the UART receiver) and writes 18-bit instructions into port A of the 1024×18 program block RAM. Holds the processor in reset for the duration of a load and releases it only after a verified checksum. Sits between the UART byte output and the program RAM write port. The processor keeps executing the preloaded image until a load begins.

---
 rtl/pb_loader_pkg.sv | 19 +
 rtl/pb_loader_timeout.sv | 29 ++
 rtl/pb_prog_loader.sv | 130 +++++++++++++
 tb/tb_pb_prog_loader.sv | 284 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pb_loader_pkg.sv
// Shared definitions for the PicoBlaze program-memory loader and the memory top level.
package pb_loader_pkg;

  localparam int unsigned INSTR_W      = 18;
  localparam int unsigned ADDR_W       = 10;
  localparam logic [7:0]  SYNC_DEFAULT = 8'hA5;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CNT_HI,
    ST_CNT_LO,
    ST_W0,
    ST_W1,
    ST_W2,
    ST_CSUM,
    ST_ERR
  } ld_state_t;

endpackage

// File: rtl/pb_loader_timeout.sv
// Inter-byte watchdog: loadable down-counter that saturates at zero and flags expiry.
module pb_loader_timeout #(
  parameter int unsigned CYCLES = 1_000_000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic load,
  input  logic en,
  output logic expired
);

  localparam int unsigned W = $clog2(CYCLES + 1);
  localparam logic [W-1:0] START = W'(CYCLES - 1);

  logic [W-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= START;
    end else if (load) begin
      cnt <= START;
    end else if (en && cnt != '0) begin
      cnt <= cnt - W'(1);
    end
  end

  assign expired = (cnt == '0);

endmodule

// File: rtl/pb_prog_loader.sv
// Framed byte-stream loader for the 1024x18 PicoBlaze program RAM; holds the CPU in
// reset while loading and releases it only after a good checksum.
module pb_prog_loader
  import pb_loader_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 1_000_000,
  parameter logic [7:0]  SYNC_BYTE      = SYNC_DEFAULT
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [7:0]         rx_data,
  input  logic               rx_valid,
  output logic               rx_ready,
  output logic [ADDR_W-1:0]  prog_addr,
  output logic [INSTR_W-1:0] prog_data,
  output logic               prog_we,
  output logic               cpu_reset,
  output logic               load_done,
  output logic               load_error
);

  localparam logic [ADDR_W:0]   MAX_WORDS = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [ADDR_W:0]   WORD_ONE  = {{ADDR_W{1'b0}}, 1'b1};
  localparam logic [ADDR_W-1:0] ADDR_ONE  = {{(ADDR_W-1){1'b0}}, 1'b1};

  ld_state_t       state, state_nxt;
  logic            accept, expired, last_word, sum_ok;
  logic [2:0]      cnt_hi;
  logic [ADDR_W:0] n_words, n_words_in;
  logic [1:0]      b0;
  logic [7:0]      b1, sum, sum_nxt;

  assign accept     = rx_valid & rx_ready;
  assign n_words_in = {cnt_hi, rx_data};
  assign sum_nxt    = sum + rx_data;
  assign sum_ok     = (sum_nxt == 8'h00);
  // prog_addr doubles as the word index: it always points at the word being assembled
  assign last_word  = ({1'b0, prog_addr} == (n_words - WORD_ONE));

  pb_loader_timeout #(
    .CYCLES (TIMEOUT_CYCLES)
  ) u_timeout (
    .clk     (clk),
    .rst_n   (rst_n),
    .load    (accept | (state == ST_IDLE)),
    .en      (state != ST_IDLE),
    .expired (expired)
  );

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (accept && rx_data == SYNC_BYTE) state_nxt = ST_CNT_HI;
      ST_ERR:  state_nxt = ST_IDLE;
      default: begin
        if (accept) begin
          case (state)
            ST_CNT_HI: state_nxt = ST_CNT_LO;
            ST_CNT_LO: state_nxt = (n_words_in == '0 || n_words_in > MAX_WORDS) ? ST_ERR : ST_W0;
            ST_W0:     state_nxt = (rx_data[7:2] != '0) ? ST_ERR : ST_W1;
            ST_W1:     state_nxt = ST_W2;
            ST_W2:     state_nxt = last_word ? ST_CSUM : ST_W0;
            ST_CSUM:   state_nxt = sum_ok ? ST_IDLE : ST_ERR;
            default:   state_nxt = ST_ERR;
          endcase
        end else if (expired) begin
          state_nxt = ST_ERR;
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      rx_ready   <= 1'b0;
      prog_addr  <= '0;
      prog_data  <= '0;
      prog_we    <= 1'b0;
      cpu_reset  <= 1'b0;
      load_done  <= 1'b0;
      load_error <= 1'b0;
    end else begin
      state     <= state_nxt;
      rx_ready  <= (state_nxt != ST_ERR);
      prog_we   <= 1'b0;
      load_done <= 1'b0;
      if (state_nxt == ST_ERR) load_error <= 1'b1;
      // the strobe after the last word lands in CSUM; holding there avoids wrapping at 1023
      if (prog_we && state != ST_CSUM) prog_addr <= prog_addr + ADDR_ONE;
      if (accept) begin
        case (state)
          ST_IDLE: begin
            if (rx_data == SYNC_BYTE) begin
              cpu_reset  <= 1'b1;
              load_error <= 1'b0;
              prog_addr  <= '0;
            end
          end
          ST_W2: begin
            prog_data <= {b0, b1, rx_data};
            prog_we   <= 1'b1;
          end
          ST_CSUM: begin
            if (sum_ok) begin
              cpu_reset <= 1'b0;
              load_done <= 1'b1;
            end
          end
          default: ;
        endcase
      end
    end
  end

  // frame payload registers: only meaningful once their byte of the current frame has arrived
  always_ff @(posedge clk) begin
    if (accept) begin
      sum <= (state == ST_IDLE) ? 8'h00 : sum_nxt;
      case (state)
        ST_CNT_HI: cnt_hi  <= rx_data[2:0];
        ST_CNT_LO: n_words <= n_words_in;
        ST_W0:     b0      <= rx_data[1:0];
        ST_W1:     b1      <= rx_data;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_pb_prog_loader.sv
// Directed bench for pb_prog_loader: good/bad frames, illegal count, noise, timeout, async reset.
`timescale 1ns/1ps
module tb_pb_prog_loader;
  import pb_loader_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [7:0]  rx_data = 8'h00;
  logic        rx_valid = 1'b0;
  logic        rx_ready, prog_we, cpu_reset, load_done, load_error;
  logic [9:0]  prog_addr;
  logic [17:0] prog_data;

  int checks = 0;
  int errors = 0;
  int nwr = 0;
  int ndone = 0;
  logic [9:0]  wa [0:63];
  logic [17:0] wd [0:63];
  logic [17:0] fw [0:15];

  always #5 clk = ~clk;

  pb_prog_loader #(
    .TIMEOUT_CYCLES (16),
    .SYNC_BYTE      (8'hA5)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .rx_data    (rx_data),
    .rx_valid   (rx_valid),
    .rx_ready   (rx_ready),
    .prog_addr  (prog_addr),
    .prog_data  (prog_data),
    .prog_we    (prog_we),
    .cpu_reset  (cpu_reset),
    .load_done  (load_done),
    .load_error (load_error)
  );

  always @(negedge clk) begin
    if (prog_we) begin
      if (nwr < 64) begin
        wa[nwr] <= prog_addr;
        wd[nwr] <= prog_data;
      end
      nwr <= nwr + 1;
    end
    if (load_done) ndone <= ndone + 1;
  end

  initial begin
    #500_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  task automatic send_byte(input logic [7:0] b);
    int n;
    n = 0;
    rx_data  = b;
    rx_valid = 1'b1;
    while (!rx_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!rx_ready) begin
      checks++;
      errors++;
      $display("FAIL handshake rx_ready got=0 exp=1 byte=%h", b);
    end
    @(posedge clk);
    #1;
    rx_valid = 1'b0;
  endtask

  task automatic send_frame(input int n, input logic [7:0] bad);
    logic [7:0]  s;
    logic [10:0] nn;
    nn = 11'(n);
    s  = 8'h00;
    send_byte(8'hA5);
    send_byte({5'b0, nn[10:8]}); s += {5'b0, nn[10:8]};
    send_byte(nn[7:0]);          s += nn[7:0];
    for (int i = 0; i < n; i++) begin
      send_byte({6'b0, fw[i][17:16]}); s += {6'b0, fw[i][17:16]};
      send_byte(fw[i][15:8]);          s += fw[i][15:8];
      send_byte(fw[i][7:0]);           s += fw[i][7:0];
    end
    send_byte(8'h00 - s + bad);
  endtask

  task automatic test_reset();
    #12;
    checks++;
    if ({rx_ready, prog_we, cpu_reset, load_done, load_error, prog_addr, prog_data} !== '0) begin
      errors++;
      $display("FAIL reset_values got=%b%b%b%b%b addr=%h data=%h exp=all zero",
               rx_ready, prog_we, cpu_reset, load_done, load_error, prog_addr, prog_data);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    checks++;
    if (rx_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got=%b exp=1", rx_ready); end
  endtask

  task automatic test_good_frame();
    int w0, d0;
    w0 = nwr; d0 = ndone;
    send_byte(8'hA5);
    checks++;
    if ({cpu_reset, load_error} !== 2'b10) begin
      errors++; $display("FAIL good_sync cpu_reset/load_error got=%b%b exp=10", cpu_reset, load_error);
    end
    send_byte(8'h00); send_byte(8'h02);
    send_byte(8'h03); send_byte(8'h0F); send_byte(8'h3F);
    checks++;
    if ({cpu_reset, prog_we, prog_addr, prog_data} !== {1'b1, 1'b1, 10'd0, 18'h30F3F}) begin
      errors++; $display("FAIL good_w0 rst=%b we=%b addr=%h data=%h exp 1 1 000 30f3f",
                         cpu_reset, prog_we, prog_addr, prog_data);
    end
    send_byte(8'h00); send_byte(8'h06); send_byte(8'h40);
    checks++;
    if ({cpu_reset, prog_we, prog_addr, prog_data} !== {1'b1, 1'b1, 10'd1, 18'h00640}) begin
      errors++; $display("FAIL good_w1 rst=%b we=%b addr=%h data=%h exp 1 1 001 00640",
                         cpu_reset, prog_we, prog_addr, prog_data);
    end
    // 0x67 brings the byte sum after SYNC (0x99) to zero
    send_byte(8'h67);
    checks++;
    if ({cpu_reset, load_done, load_error, prog_we, prog_addr} !== {4'b0100, 10'd1}) begin
      errors++; $display("FAIL good_csum rst=%b done=%b err=%b we=%b addr=%h exp 0 1 0 0 001",
                         cpu_reset, load_done, load_error, prog_we, prog_addr);
    end
    @(posedge clk);
    #1;
    checks++;
    if (load_done !== 1'b0 || ndone - d0 != 1) begin
      errors++; $display("FAIL good_done_pulse done=%b count=%0d exp 0 1", load_done, ndone - d0);
    end
    checks++;
    if (nwr - w0 != 2) begin errors++; $display("FAIL good_write_count got=%0d exp=2", nwr - w0); end
  endtask

  task automatic test_noise_malformed();
    int w0;
    w0 = nwr;
    send_byte(8'h00); send_byte(8'hFF); send_byte(8'h12);
    checks++;
    if ({cpu_reset, load_error, rx_ready} !== 3'b001 || nwr != w0) begin
      errors++; $display("FAIL noise_ignored rst=%b err=%b rdy=%b writes=%0d exp 0 0 1 0",
                         cpu_reset, load_error, rx_ready, nwr - w0);
    end
    send_byte(8'hA5); send_byte(8'h00); send_byte(8'h01);
    send_byte(8'h04);
    checks++;
    if ({load_error, cpu_reset, rx_ready} !== 3'b110) begin
      errors++; $display("FAIL malformed_b0 err=%b rst=%b rdy=%b exp 1 1 0", load_error, cpu_reset, rx_ready);
    end
  endtask

  task automatic test_bad_csum();
    int w0, d0;
    w0 = nwr; d0 = ndone;
    send_byte(8'hA5);
    checks++;
    if (load_error !== 1'b0) begin errors++; $display("FAIL bad_sync_clear err got=%b exp=0", load_error); end
    send_byte(8'h00); send_byte(8'h02);
    send_byte(8'h03); send_byte(8'h0F); send_byte(8'h3F);
    send_byte(8'h00); send_byte(8'h06); send_byte(8'h40);
    send_byte(8'h68);
    checks++;
    if ({load_error, cpu_reset, load_done} !== 3'b110) begin
      errors++; $display("FAIL bad_csum err=%b rst=%b done=%b exp 1 1 0", load_error, cpu_reset, load_done);
    end
    @(posedge clk);
    #1;
    checks++;
    if (nwr - w0 != 2 || wd[w0] !== 18'h30F3F || wd[w0+1] !== 18'h00640 || ndone != d0) begin
      errors++; $display("FAIL bad_csum_writes n=%0d d0=%h d1=%h done=%0d exp 2 30f3f 00640 0",
                         nwr - w0, wd[w0], wd[w0+1], ndone - d0);
    end
  endtask

  task automatic test_illegal_count();
    int w0;
    w0 = nwr;
    send_byte(8'hA5); send_byte(8'h04);
    checks++;
    if (load_error !== 1'b0) begin errors++; $display("FAIL cnt_pre_err got=%b exp=0", load_error); end
    send_byte(8'h01);
    checks++;
    if ({load_error, cpu_reset} !== 2'b11) begin
      errors++; $display("FAIL cnt_1025 err=%b rst=%b exp 1 1", load_error, cpu_reset);
    end
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (nwr != w0) begin errors++; $display("FAIL cnt_no_write got=%0d exp=0", nwr - w0); end
  endtask

  task automatic test_timeout();
    int d0;
    send_byte(8'hA5); send_byte(8'h00);
    repeat (15) @(posedge clk);
    #1;
    checks++;
    if (load_error !== 1'b0) begin errors++; $display("FAIL tmo_early err got=%b exp=0", load_error); end
    @(posedge clk);
    #1;
    checks++;
    if ({load_error, cpu_reset} !== 2'b11) begin
      errors++; $display("FAIL tmo_fire err=%b rst=%b exp 1 1", load_error, cpu_reset);
    end
    d0 = ndone;
    fw[0] = 18'h1_2345; fw[1] = 18'h2_ABCD;
    send_frame(2, 8'h00);
    @(posedge clk);
    #1;
    checks++;
    if ({load_error, cpu_reset} !== 2'b00 || ndone - d0 != 1) begin
      errors++; $display("FAIL tmo_recover err=%b rst=%b done=%0d exp 0 0 1", load_error, cpu_reset, ndone - d0);
    end
  endtask

  task automatic test_reset_mid_frame();
    int w0, d0;
    logic [7:0] b;
    for (int i = 0; i < 8; i++) fw[i] = 18'h2_0000 + 18'(i * 18'h111);
    w0 = nwr;
    send_byte(8'hA5); send_byte(8'h00); send_byte(8'h08);
    for (int i = 0; i < 5; i++) begin
      b = {6'b0, fw[i][17:16]}; send_byte(b);
      b = fw[i][15:8];          send_byte(b);
      b = fw[i][7:0];           send_byte(b);
    end
    b = {6'b0, fw[5][17:16]};
    send_byte(b);
    rst_n = 1'b0;
    #1;
    checks++;
    if ({rx_ready, prog_we, cpu_reset, load_done, load_error, prog_addr, prog_data} !== '0) begin
      errors++; $display("FAIL async_reset rdy=%b we=%b rst=%b done=%b err=%b addr=%h data=%h exp all zero",
                         rx_ready, prog_we, cpu_reset, load_done, load_error, prog_addr, prog_data);
    end
    checks++;
    if (nwr - w0 != 5 || wa[w0+4] !== 10'd4 || wd[w0+4] !== 18'h2_0444) begin
      errors++; $display("FAIL partial_writes n=%0d addr=%h data=%h exp 5 004 20444",
                         nwr - w0, wa[w0+4], wd[w0+4]);
    end
    @(negedge clk);
    rst_n = 1'b1;
    fw[0] = 18'h0_0001; fw[1] = 18'h3_FFFF; fw[2] = 18'h1_8000;
    w0 = nwr; d0 = ndone;
    send_frame(3, 8'h00);
    @(posedge clk);
    #1;
    checks++;
    if (nwr - w0 != 3 || wa[w0] !== 10'd0 || wa[w0+2] !== 10'd2 ||
        wd[w0] !== 18'h0_0001 || wd[w0+1] !== 18'h3_FFFF || wd[w0+2] !== 18'h1_8000) begin
      errors++; $display("FAIL reload_writes n=%0d a0=%h a2=%h d0=%h d1=%h d2=%h exp 3 000 002 00001 3ffff 18000",
                         nwr - w0, wa[w0], wa[w0+2], wd[w0], wd[w0+1], wd[w0+2]);
    end
    checks++;
    if ({cpu_reset, load_error} !== 2'b00 || ndone - d0 != 1) begin
      errors++; $display("FAIL reload_done rst=%b err=%b done=%0d exp 0 0 1", cpu_reset, load_error, ndone - d0);
    end
  endtask

  initial begin
    test_reset();
    test_good_frame();
    test_noise_malformed();
    test_bad_csum();
    test_illegal_count();
    test_timeout();
    test_reset_mid_frame();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
